// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole round sequencer.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        DONE
    } state_t;

    localparam int NUM_MOLES = 5;

    // Fibonacci feedback taps for x^5 + x^3 + 1 (bits 4 and 2).
    localparam logic [4:0] LFSR_TAPS = 5'b10100;

    function automatic int ms_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Prescaler that emits a one-cycle tick every millisecond.
module ms_tick_gen
    import whack_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int DIV = ms_div(CLK_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign o_tick = w_wrap && !i_clr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole game sequencer: mole select, timed window, hit/miss judging.
module mole_round_ctrl
    import whack_pkg::*;
#(
    parameter int         CLK_HZ    = 100_000_000,
    parameter int         MOLE_MS   = 1000,
    parameter int         GAP_MS    = 250,
    parameter int         ROUNDS    = 30,
    parameter logic [4:0] LFSR_SEED = 5'h1B
) (
    input  logic       MHz100_clk_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic [4:0] whack_i,
    output logic [4:0] LED_o,
    output logic [4:0] round_o,
    output logic       hit_o,
    output logic       miss_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int MSW = 16;

    state_t         r_state;
    state_t         w_next;
    logic [4:0]     r_lfsr;
    logic [4:0]     r_whack_q;
    logic [4:0]     r_led;
    logic [4:0]     r_round;
    logic [2:0]     r_prev_idx;
    logic [MSW-1:0] r_ms_cnt;
    logic           r_hit;
    logic           r_miss;
    logic           r_busy;
    logic           r_done;

    logic [4:0]     w_press;
    logic [2:0]     w_raw_idx;
    logic [2:0]     w_idx;
    logic           w_tick;
    logic           w_show_to;
    logic           w_gap_to;
    logic           w_hit;
    logic           w_miss;
    logic           w_enter_show;

    ms_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .i_clk   (MHz100_clk_i),
        .i_rst_n (reset_n_i),
        .i_clr   (r_state == IDLE),
        .o_tick  (w_tick)
    );

    assign w_press   = whack_i & ~r_whack_q;
    assign w_raw_idx = 3'(r_lfsr % NUM_MOLES);

    // Bump to the next mole so the same one never lights twice in a row.
    assign w_idx = (w_raw_idx != r_prev_idx)          ? w_raw_idx :
                   (w_raw_idx == 3'(NUM_MOLES - 1))   ? 3'd0      :
                                                        w_raw_idx + 3'd1;

    assign w_show_to = w_tick && (r_ms_cnt == MSW'(MOLE_MS - 1));
    assign w_gap_to  = w_tick && (r_ms_cnt == MSW'(GAP_MS - 1));

    always_comb begin
        w_next = r_state;
        w_hit  = 1'b0;
        w_miss = 1'b0;
        unique case (r_state)
            IDLE, DONE: begin
                if (start_i) w_next = SHOW;
            end
            SHOW: begin
                if (|w_press) begin
                    w_hit  = |(w_press & r_led);
                    w_miss = ~w_hit;
                    w_next = GAP;
                end else if (w_show_to) begin
                    w_miss = 1'b1;
                    w_next = GAP;
                end
            end
            GAP: begin
                if (w_gap_to) begin
                    w_next = (r_round == 5'(ROUNDS)) ? DONE : SHOW;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_enter_show = (w_next == SHOW) && (r_state != SHOW);

    always_ff @(posedge MHz100_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge MHz100_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_lfsr     <= LFSR_SEED;
            r_whack_q  <= '0;
            r_led      <= '0;
            r_round    <= '0;
            r_prev_idx <= '0;
            r_ms_cnt   <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_lfsr    <= {r_lfsr[3:0], ^(r_lfsr & LFSR_TAPS)};
            r_whack_q <= whack_i;
            r_hit     <= w_hit;
            r_miss    <= w_miss;
            r_busy    <= (w_next == SHOW) || (w_next == GAP);
            r_done    <= (w_next == DONE);
            if (w_next != r_state) begin
                r_ms_cnt <= '0;
            end else if (w_tick) begin
                r_ms_cnt <= r_ms_cnt + 1'b1;
            end
            if (w_enter_show) begin
                r_led      <= 5'b00001 << w_idx;
                r_prev_idx <= w_idx;
                r_round    <= (r_state == GAP) ? r_round + 5'd1 : 5'd1;
            end else if (w_next != SHOW) begin
                r_led <= '0;
            end
        end
    end

    assign LED_o   = r_led;
    assign round_o = r_round;
    assign hit_o   = r_hit;
    assign miss_o  = r_miss;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Randomized bench for mole_round_ctrl against a game-level reference model.
module tb_mole_round_ctrl;

    localparam int MOLE_MS = 4;
    localparam int GAP_MS  = 2;
    localparam int ROUNDS  = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] whack = '0;
    logic [4:0] led;
    logic [4:0] rnd;
    logic       hit;
    logic       miss;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mole_round_ctrl #(
        .CLK_HZ    (1000),
        .MOLE_MS   (MOLE_MS),
        .GAP_MS    (GAP_MS),
        .ROUNDS    (ROUNDS),
        .LFSR_SEED (5'h1B)
    ) dut (
        .MHz100_clk_i (clk),
        .reset_n_i    (rst_n),
        .start_i      (start),
        .whack_i      (whack),
        .LED_o        (led),
        .round_o      (rnd),
        .hit_o        (hit),
        .miss_o       (miss),
        .busy_o       (busy),
        .done_o       (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 mole shown, 2 blank gap, 3 game over.
    // With a 1 kHz clock every cycle is one millisecond.
    int         m_phase = 0;
    int         m_age   = 0;
    int         m_round = 0;
    int         m_prev  = 0;
    int         m_games = 0;
    logic [4:0] m_lfsr  = 5'h1B;
    logic [4:0] m_wq    = '0;
    logic [4:0] m_led   = '0;
    bit         m_hit   = 1'b0;
    bit         m_miss  = 1'b0;

    task automatic m_reset();
        m_phase = 0;
        m_age   = 0;
        m_round = 0;
        m_prev  = 0;
        m_lfsr  = 5'h1B;
        m_wq    = '0;
        m_led   = '0;
        m_hit   = 1'b0;
        m_miss  = 1'b0;
    endtask

    task automatic m_step(input bit st, input logic [4:0] wh);
        logic [4:0] press;
        int         pick;
        int         nphase;
        bit         show_new;
        press    = wh & ~m_wq;
        pick     = int'(m_lfsr) % 5;
        if (pick == m_prev) pick = (pick + 1) % 5;
        m_hit    = 1'b0;
        m_miss   = 1'b0;
        show_new = 1'b0;
        nphase   = m_phase;
        if (m_phase == 0 || m_phase == 3) begin
            if (st) begin
                show_new = 1'b1;
                m_round  = 1;
            end
        end else if (m_phase == 1) begin
            if (press != 0) begin
                if ((press & m_led) != 0) m_hit = 1'b1;
                else m_miss = 1'b1;
                nphase = 2;
            end else if (m_age + 1 >= MOLE_MS) begin
                m_miss = 1'b1;
                nphase = 2;
            end
        end else if (m_age + 1 >= GAP_MS) begin
            if (m_round == ROUNDS) begin
                nphase = 3;
                m_games++;
            end else begin
                show_new = 1'b1;
                m_round++;
            end
        end
        if (show_new) begin
            m_led   = 5'(1 << pick);
            m_prev  = pick;
            m_phase = 1;
            m_age   = 0;
        end else begin
            if (nphase != m_phase) begin
                m_age = 0;
                m_led = '0;
            end else begin
                m_age++;
            end
            m_phase = nphase;
        end
        m_wq   = wh;
        m_lfsr = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    endtask

    task automatic cyc(input bit st, input logic [4:0] wh);
        start = st;
        whack = wh;
        @(posedge clk);
        m_step(st, wh);
        #1;
    endtask

    // Per-cycle compare plus game-level invariants.
    int         rst_gen   = 0;
    int         seen_gen  = 0;
    int         pulses    = 0;
    logic [4:0] last_mole = '0;
    logic [4:0] prev_led  = '0;

    always @(negedge clk) begin
        if (seen_gen != rst_gen) begin
            last_mole = '0;
            prev_led  = '0;
            pulses    = 0;
            seen_gen  = rst_gen;
        end
        chk("LED_o", int'(led), int'(m_led));
        chk("round_o", int'(rnd), m_round);
        chk("hit_o", int'(hit), int'(m_hit));
        chk("miss_o", int'(miss), int'(m_miss));
        chk("busy_o", int'(busy), int'(m_phase == 1 || m_phase == 2));
        chk("done_o", int'(done), int'(m_phase == 3));
        chk("led_onehot", int'($countones(led) <= 1), 1);
        chk("hit_and_miss", int'(hit & miss), 0);
        if (led != 0 && prev_led == 0) begin
            if (last_mole != 0) chk("repeat_mole", int'(led != last_mole), 1);
            last_mole = led;
            pulses    = 0;
        end
        if (hit || miss) begin
            pulses++;
            chk("pulses_per_round", int'(pulses <= 1), 1);
        end
        prev_led = led;
    end

    initial begin
        logic [4:0] wh;
        logic [4:0] unlit;
        int         r;
        int         cycles;

        m_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_LED", int'(led), 0);
        chk("reset_round", int'(rnd), 0);
        chk("reset_busy", int'(busy), 0);
        rst_n = 1'b1;

        cyc(1'b1, 5'b00000);
        chk("start_LED", int'(led), 5'b00100);
        chk("start_round", int'(rnd), 1);
        chk("start_busy", int'(busy), 1);
        cyc(1'b0, 5'b00000);
        cyc(1'b0, 5'b00100);
        chk("hit_pulse", int'(hit), 1);
        chk("hit_LED_off", int'(led), 0);
        cyc(1'b0, 5'b00010);
        chk("hit_once", int'(hit), 0);
        chk("gap_LED", int'(led), 0);
        cyc(1'b0, 5'b00010);
        chk("second_mole", int'(led), 5'b00010);
        chk("second_round", int'(rnd), 2);
        cyc(1'b0, 5'b00010);
        chk("held_no_hit", int'(hit), 0);
        chk("held_no_miss", int'(miss), 0);
        cyc(1'b0, 5'b00000);
        chk("release_no_pulse", int'(hit | miss), 0);
        cyc(1'b0, 5'b00010);
        chk("repress_hit", int'(hit), 1);

        cyc(1'b1, 5'b00000);
        cyc(1'b0, 5'b00000);
        chk("third_round", int'(rnd), 3);
        cyc(1'b1, 5'b00000);
        chk("start_in_show", int'(rnd), 3);
        cyc(1'b0, 5'b00000);
        cyc(1'b0, 5'b00000);
        chk("no_early_timeout", int'(miss), 0);
        cyc(1'b0, 5'b00000);
        chk("timeout_miss", int'(miss), 1);
        chk("timeout_no_hit", int'(hit), 0);
        cyc(1'b0, 5'b00000);
        cyc(1'b0, 5'b00000);
        chk("done_flag", int'(done), 1);
        chk("done_round", int'(rnd), 3);
        chk("done_LED", int'(led), 0);
        chk("done_busy", int'(busy), 0);
        cyc(1'b0, 5'b00000);
        cyc(1'b1, 5'b00000);
        chk("restart_round", int'(rnd), 1);
        chk("restart_busy", int'(busy), 1);

        unlit = {m_led[3:0], m_led[4]};
        cyc(1'b0, m_led | unlit);
        chk("mixed_hit", int'(hit), 1);
        chk("mixed_no_miss", int'(miss), 0);
        cyc(1'b0, 5'b00000);
        cyc(1'b0, 5'b00000);
        unlit = {m_led[3:0], m_led[4]};
        cyc(1'b0, unlit);
        chk("wrong_miss", int'(miss), 1);
        chk("wrong_no_hit", int'(hit), 0);
        cyc(1'b0, 5'b00000);
        cyc(1'b0, 5'b00000);
        cyc(1'b0, 5'b00000);
        chk("pre_reset_busy", int'(busy), 1);

        rst_n = 1'b0;
        m_reset();
        rst_gen++;
        #1;
        chk("async_LED", int'(led), 0);
        chk("async_round", int'(rnd), 0);
        chk("async_pulse", int'(hit | miss), 0);
        chk("async_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 5'b00000);
        chk("post_reset_LED", int'(led), 5'b00100);

        m_games = 0;
        cycles  = 0;
        wh      = '0;
        while (m_games < 1000 && cycles < 60000) begin
            r = $urandom_range(0, 7);
            if (r <= 2) wh = '0;
            else if (r == 3) wh = m_led;
            else if (r == 4) wh = 5'($urandom_range(0, 31));
            cyc($urandom_range(0, 3) == 0, wh);
            cycles++;
        end
        chk("games_completed", int'(m_games >= 1000), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
